// File: rtl/game_score_pkg.sv
// Shared definitions for the tunnel-game score keeper: FSM encoding,
// blank digit code and level thresholds (packed BCD).
package game_score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam logic [4:0]  BLANK_CODE_DEF = 5'h1F;

    localparam logic [15:0] LVL1_TH = 16'h0100;
    localparam logic [15:0] LVL2_TH = 16'h0500;
    localparam logic [15:0] LVL3_TH = 16'h1000;

    // Packed BCD orders the same as binary, so a plain unsigned compare works.
    function automatic logic [1:0] level_of(input logic [15:0] s);
        if (s < LVL1_TH)      return 2'd0;
        else if (s < LVL2_TH) return 2'd1;
        else if (s < LVL3_TH) return 2'd2;
        else                  return 2'd3;
    endfunction

endpackage

// File: rtl/game_score_keeper_bcd_inc4.sv
// Combinational 4-digit packed-BCD incrementer, saturating at 9999.
module bcd_inc4 (
    input  logic [15:0] bcd_in,
    output logic [15:0] bcd_out,
    output logic        sat
);

    logic carry;

    always_comb begin
        sat     = (bcd_in == 16'h9999);
        bcd_out = bcd_in;
        carry   = ~sat;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd_in[4*i +: 4] == 4'd9) begin
                    bcd_out[4*i +: 4] = 4'd0;
                end else begin
                    bcd_out[4*i +: 4] = bcd_in[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/game_score_keeper.sv
// Score, timer and high-score keeper with seven-segment digit codes.
// Optional high-score feature: define GAME_SCORE_HISCORE_EN.
module game_score_keeper
    import game_score_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 10_000_000,
    parameter logic [4:0]  BLANK_CODE = BLANK_CODE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause,
    input  logic        collision,
    input  logic        show_hi,
    input  logic        clr_hi,
    output logic [15:0] score_bcd,
    output logic [15:0] hi_bcd,
    output logic [4:0]  dig3,
    output logic [4:0]  dig2,
    output logic [4:0]  dig1,
    output logic [4:0]  dig0,
    output logic [3:0]  dp,
    output logic [1:0]  level,
    output logic        running,
    output logic        game_over
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic [15:0]   score_q, score_d, score_base, score_inc;
    logic [15:0]   hi_q, hi_d, disp_src;
    logic [PW-1:0] presc_q, presc_d;
    logic          ign_q, ign_d;
    logic          start_prev_q, pause_prev_q;
    logic          start_edge, pause_edge, tick, sat;
    logic [1:0]    level_q, level_d;
    logic [4:0]    dig3_q, dig2_q, dig1_q, dig0_q;
    logic [4:0]    dig3_d, dig2_d, dig1_d, dig0_d;
    logic [3:0]    dp_q, dp_d;
    logic          running_q, over_q;

    assign start_edge = start & ~start_prev_q;
    assign pause_edge = pause & ~pause_prev_q;

    bcd_inc4 u_inc (
        .bcd_in  (score_q),
        .bcd_out (score_inc),
        .sat     (sat)
    );

    // ign_q masks collision only on the first RUN cycle after a restart from OVER.
    always_comb begin
        state_d    = state_q;
        score_base = score_q;
        presc_d    = presc_q;
        hi_d       = hi_q;
        ign_d      = 1'b0;
        tick       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
`ifdef GAME_SCORE_HISCORE_EN
                if (clr_hi) hi_d = '0;
`endif
                if (start_edge) begin
                    state_d    = ST_RUN;
                    score_base = '0;
                    presc_d    = '0;
                end
            end
            ST_RUN: begin
                if (collision && !ign_q) begin
                    state_d = ST_OVER;
`ifdef GAME_SCORE_HISCORE_EN
                    if (score_q > hi_q) hi_d = score_q;
`endif
                end else begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        tick    = 1'b1;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    if (pause_edge) state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_edge) state_d = ST_RUN;
            end
            ST_OVER: begin
`ifdef GAME_SCORE_HISCORE_EN
                if (clr_hi) hi_d = '0;
`endif
                if (start_edge) begin
                    state_d    = ST_RUN;
                    score_base = '0;
                    presc_d    = '0;
                    ign_d      = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        score_d = (tick && !sat) ? score_inc : score_base;
        level_d = level_of(score_d);
    end

`ifdef GAME_SCORE_HISCORE_EN
    assign disp_src = show_hi ? hi_q : score_q;
`else
    logic unused_hi_inputs;
    assign unused_hi_inputs = show_hi ^ clr_hi;
    assign disp_src         = score_q;
`endif

    always_comb begin
        dig3_d = (disp_src[15:12] == 4'd0) ? BLANK_CODE : {1'b0, disp_src[15:12]};
        dig2_d = (disp_src[15:8]  == 8'd0) ? BLANK_CODE : {1'b0, disp_src[11:8]};
        dig1_d = (disp_src[15:4]  == 12'd0) ? BLANK_CODE : {1'b0, disp_src[7:4]};
        dig0_d = {1'b0, disp_src[3:0]};
        dp_d   = {state_q == ST_OVER, 2'b00, state_q == ST_PAUSE};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            score_q      <= '0;
            hi_q         <= '0;
            presc_q      <= '0;
            ign_q        <= 1'b0;
            start_prev_q <= 1'b1;
            pause_prev_q <= 1'b1;
            level_q      <= '0;
            running_q    <= 1'b0;
            over_q       <= 1'b0;
            dig3_q       <= BLANK_CODE;
            dig2_q       <= BLANK_CODE;
            dig1_q       <= BLANK_CODE;
            dig0_q       <= '0;
            dp_q         <= '0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            hi_q         <= hi_d;
            presc_q      <= presc_d;
            ign_q        <= ign_d;
            start_prev_q <= start;
            pause_prev_q <= pause;
            level_q      <= level_d;
            running_q    <= (state_d == ST_RUN);
            over_q       <= (state_d == ST_OVER);
            dig3_q       <= dig3_d;
            dig2_q       <= dig2_d;
            dig1_q       <= dig1_d;
            dig0_q       <= dig0_d;
            dp_q         <= dp_d;
        end
    end

    assign score_bcd = score_q;
`ifdef GAME_SCORE_HISCORE_EN
    assign hi_bcd    = hi_q;
`else
    assign hi_bcd    = '0;
`endif
    assign dig3      = dig3_q;
    assign dig2      = dig2_q;
    assign dig1      = dig1_q;
    assign dig0      = dig0_q;
    assign dp        = dp_q;
    assign level     = level_q;
    assign running   = running_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_game_score_keeper.sv
// Self-checking bench for game_score_keeper against an integer-level game model.
module tb_game_score_keeper;

    localparam int unsigned TD = 4;
    localparam logic [4:0]  BLK = 5'h1F;
`ifdef GAME_SCORE_HISCORE_EN
    localparam bit HI = 1'b1;
`else
    localparam bit HI = 1'b0;
`endif
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_OVER = 3;

    logic        clk = 1'b0;
    logic        rst_n, start, pause, collision, show_hi, clr_hi;
    logic [15:0] score_bcd, hi_bcd;
    logic [4:0]  dig3, dig2, dig1, dig0;
    logic [3:0]  dp;
    logic [1:0]  level;
    logic        running, game_over;

    game_score_keeper #(.TICK_DIV(TD), .BLANK_CODE(BLK)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
        .collision(collision), .show_hi(show_hi), .clr_hi(clr_hi),
        .score_bcd(score_bcd), .hi_bcd(hi_bcd),
        .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
        .dp(dp), .level(level), .running(running), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    int         m_state, m_score, m_hi, m_presc;
    bit         m_ign, m_prev_s, m_prev_p;
    logic [4:0] m_d3, m_d2, m_d1, m_d0;
    logic [3:0] m_dp;
    int         m_level;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int lvl(input int v);
        if (v < 100) return 0;
        if (v < 500) return 1;
        if (v < 1000) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_score = 0; m_hi = 0; m_presc = 0; m_ign = 0;
        m_prev_s = 1; m_prev_p = 1; m_level = 0;
        m_d3 = BLK; m_d2 = BLK; m_d1 = BLK; m_d0 = 5'd0; m_dp = 4'd0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit c, input bit sh, input bit ch);
        bit se, pe;
        int src;
        se  = s && !m_prev_s;
        pe  = p && !m_prev_p;
        src = (HI && sh) ? m_hi : m_score;
        m_d3 = (src < 1000) ? BLK : 5'(src / 1000);
        m_d2 = (src < 100)  ? BLK : 5'(src / 100 % 10);
        m_d1 = (src < 10)   ? BLK : 5'(src / 10 % 10);
        m_d0 = 5'(src % 10);
        m_dp = {m_state == M_OVER, 2'b00, m_state == M_PAUSE};
        case (m_state)
            M_IDLE, M_OVER: begin
                if (HI && ch) m_hi = 0;
                if (se) begin
                    m_ign   = (m_state == M_OVER);
                    m_state = M_RUN; m_score = 0; m_presc = 0;
                end
            end
            M_RUN: begin
                if (c && !m_ign) begin
                    m_state = M_OVER;
                    if (HI && m_score > m_hi) m_hi = m_score;
                end else begin
                    m_presc++;
                    if (m_presc == TD) begin
                        m_presc = 0;
                        if (m_score < 9999) m_score++;
                    end
                    if (pe) m_state = M_PAUSE;
                end
                m_ign = 0;
            end
            default: if (pe) m_state = M_RUN;
        endcase
        m_level  = lvl(m_score);
        m_prev_s = s;
        m_prev_p = p;
    endtask

    task automatic check_all();
        check_val("score",     score_bcd, to_bcd(m_score));
        check_val("hi",        hi_bcd,    to_bcd(m_hi));
        check_val("dig3",      16'(dig3), 16'(m_d3));
        check_val("dig2",      16'(dig2), 16'(m_d2));
        check_val("dig1",      16'(dig1), 16'(m_d1));
        check_val("dig0",      16'(dig0), 16'(m_d0));
        check_val("dp",        16'(dp),   16'(m_dp));
        check_val("level",     16'(level), 16'(m_level));
        check_val("running",   16'(running),   16'(m_state == M_RUN));
        check_val("game_over", 16'(game_over), 16'(m_state == M_OVER));
    endtask

    task automatic step(input bit s, input bit p, input bit c, input bit sh, input bit ch);
        start = s; pause = p; collision = c; show_hi = sh; clr_hi = ch;
        model_step(s, p, c, sh, ch);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 50000 && m_score < target; i++) step(0, 0, 0, 0, 0);
        check_val("reach_score", to_bcd(m_score), to_bcd(target));
    endtask

    initial begin
        rst_n = 1'b0; start = 0; pause = 0; collision = 0; show_hi = 0; clr_hi = 0;
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        idle_n(2);

        // first game: start, first tick, pause mid-count, resume
        step(1, 0, 0, 0, 0);
        idle_n(6);
        run_to(100);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        idle_n(20);
        step(0, 1, 0, 0, 0);
        idle_n(10);

        // game ends at 123, then a shorter game ends at 50
        run_to(123);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0);
        run_to(50);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // restart with collision held: one-cycle mask, then collision takes effect
        step(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // clr_hi in RUN ignored; collision beats pause edge; clr_hi in OVER clears
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);

        // saturation
        step(1, 0, 0, 0, 0);
        run_to(9998);
        for (int i = 0; i < 3 * TD + 2; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);

        // randomized play
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 47) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 31) == 0);

        // asynchronous reset mid-RUN with start held through it
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        run_to(42);
        step(1, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle_n(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog at %0t: got timeout expected finish", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
